// File: rtl/updown_seq_checker_if.sv
// Signal bundle between a 3-bit up/down counter and its sequence checker:
// the monitored counter signals plus the checker's status outputs.
interface updown_seq_checker_if #(
  parameter int CNT_W = 8
);
  logic             cnt_dir;
  logic [2:0]       y_in;
  logic             step_ok;
  logic             err_flag;
  logic [1:0]       dir_state;
  logic [CNT_W-1:0] wrap_up_cnt;
  logic [CNT_W-1:0] wrap_dn_cnt;
  logic [CNT_W-1:0] mism_cnt;

  modport master (
    output cnt_dir,
    output y_in,
    input  step_ok,
    input  err_flag,
    input  dir_state,
    input  wrap_up_cnt,
    input  wrap_dn_cnt,
    input  mism_cnt
  );

  modport slave (
    input  cnt_dir,
    input  y_in,
    output step_ok,
    output err_flag,
    output dir_state,
    output wrap_up_cnt,
    output wrap_dn_cnt,
    output mism_cnt
  );
endinterface

// File: rtl/updown_seq_checker.sv
// Checks a 3-bit up/down counter against the expected +/-1 mod-8 sequence.
// Optional macro SEQCHK_HOLD_EN makes a held value (stalled counter) legal.
module updown_seq_checker #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  updown_seq_checker_if.slave chk
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE   = 2'b00,
    DIR_UP     = 2'b01,
    DIR_DN     = 2'b10,
    DIR_RESYNC = 2'b11
  } dir_code_t;

  state_t           state_q,     state_d;
  logic [2:0]       prev_y_q,    prev_y_d;
  logic             dir_q;
  logic             step_ok_q,   step_ok_d;
  logic             err_q,       err_d;
  dir_code_t        dir_state_q, dir_state_d;
  logic [CNT_W-1:0] wrap_up_q,   wrap_up_d;
  logic [CNT_W-1:0] wrap_dn_q,   wrap_dn_d;
  logic [CNT_W-1:0] mism_q,      mism_d;

  logic [2:0]       expected_y;
  logic             is_match;
  logic             hold_legal;
  dir_code_t        track_code;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // dir_q is the direction the counter applied when it produced the current y_in.
  always_comb begin
    expected_y = dir_q ? prev_y_q + 3'd1 : prev_y_q - 3'd1;
    is_match   = (chk.y_in == expected_y);
    track_code = dir_q ? DIR_UP : DIR_DN;
`ifdef SEQCHK_HOLD_EN
    hold_legal = (chk.y_in == prev_y_q);
`else
    hold_legal = 1'b0;
`endif
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb infers a latch.
    state_d     = state_q;
    prev_y_d    = prev_y_q;
    step_ok_d   = 1'b0;
    err_d       = err_q;
    dir_state_d = dir_state_q;
    wrap_up_d   = wrap_up_q;
    wrap_dn_d   = wrap_dn_q;
    mism_d      = mism_q;

    unique case (state_q)
      IDLE: begin
        prev_y_d    = chk.y_in;
        dir_state_d = DIR_NONE;
        state_d     = TRACK;
      end

      TRACK: begin
        if (is_match) begin
          step_ok_d   = 1'b1;
          prev_y_d    = chk.y_in;
          dir_state_d = track_code;
          if (dir_q && prev_y_q == 3'd7 && chk.y_in == 3'd0)
            wrap_up_d = sat_inc(wrap_up_q);
          if (!dir_q && prev_y_q == 3'd0 && chk.y_in == 3'd7)
            wrap_dn_d = sat_inc(wrap_dn_q);
        end else if (hold_legal) begin
          // Stalled counter: nothing changes, step_ok stays low.
          state_d = TRACK;
        end else begin
          err_d       = 1'b1;
          mism_d      = sat_inc(mism_q);
          prev_y_d    = chk.y_in;
          dir_state_d = DIR_RESYNC;
          state_d     = RESYNC;
        end
      end

      RESYNC: begin
        // Re-anchor on the current value without judging it.
        prev_y_d    = chk.y_in;
        dir_state_d = track_code;
        state_d     = TRACK;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= IDLE;
      prev_y_q    <= 3'd0;
      dir_q       <= 1'b0;
      step_ok_q   <= 1'b0;
      err_q       <= 1'b0;
      dir_state_q <= DIR_NONE;
      wrap_up_q   <= '0;
      wrap_dn_q   <= '0;
      mism_q      <= '0;
    end else begin
      state_q     <= state_d;
      prev_y_q    <= prev_y_d;
      dir_q       <= chk.cnt_dir;
      step_ok_q   <= step_ok_d;
      err_q       <= err_d;
      dir_state_q <= dir_state_d;
      wrap_up_q   <= wrap_up_d;
      wrap_dn_q   <= wrap_dn_d;
      mism_q      <= mism_d;
    end
  end

  assign chk.step_ok     = step_ok_q;
  assign chk.err_flag    = err_q;
  assign chk.dir_state   = dir_state_q;
  assign chk.wrap_up_cnt = wrap_up_q;
  assign chk.wrap_dn_cnt = wrap_dn_q;
  assign chk.mism_cnt    = mism_q;

endmodule

// File: tb/tb_updown_seq_checker.sv
// Self-checking bench for updown_seq_checker: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_updown_seq_checker;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQCHK_HOLD_EN
  localparam bit HOLD_OK = 1'b1;
`else
  localparam bit HOLD_OK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  bit   cmp_en = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  updown_seq_checker_if #(.CNT_W(CNT_W)) chk ();

  updown_seq_checker #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .chk (chk)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 = waiting for the first sample, 1 = judging
  // steps, 2 = skipping one sample after an illegal step.
  int m_phase = 0;
  int m_prev  = 0;
  int m_dir   = 0;
  int e_step_ok = 0, e_err = 0, e_dir_state = 0, e_up = 0, e_dn = 0, e_mism = 0;

  always @(posedge clk) begin
    int y;
    int want;
    y = int'(chk.y_in);
    if (rst !== 1'b1) begin
      m_phase = 0; m_prev = 0;
      e_step_ok = 0; e_err = 0; e_dir_state = 0; e_up = 0; e_dn = 0; e_mism = 0;
      m_dir = 0;
    end else begin
      want = (m_dir != 0) ? (m_prev + 1) % 8 : (m_prev + 7) % 8;
      e_step_ok = 0;
      if (m_phase == 0) begin
        m_prev  = y;
        m_phase = 1;
      end else if (m_phase == 2) begin
        m_prev      = y;
        m_phase     = 1;
        e_dir_state = (m_dir != 0) ? 1 : 2;
      end else if (y == want) begin
        e_step_ok   = 1;
        e_dir_state = (m_dir != 0) ? 1 : 2;
        if (m_dir != 0 && m_prev == 7 && y == 0 && e_up < CNT_MAX) e_up++;
        if (m_dir == 0 && m_prev == 0 && y == 7 && e_dn < CNT_MAX) e_dn++;
        m_prev = y;
      end else if (HOLD_OK && y == m_prev) begin
        m_prev = y;
      end else begin
        e_err       = 1;
        e_dir_state = 3;
        if (e_mism < CNT_MAX) e_mism++;
        m_prev  = y;
        m_phase = 2;
      end
      m_dir = int'(chk.cnt_dir);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("step_ok",     32'(chk.step_ok),     e_step_ok);
      check("err_flag",    32'(chk.err_flag),    e_err);
      check("dir_state",   32'(chk.dir_state),   e_dir_state);
      check("wrap_up_cnt", 32'(chk.wrap_up_cnt), e_up);
      check("wrap_dn_cnt", 32'(chk.wrap_dn_cnt), e_dn);
      check("mism_cnt",    32'(chk.mism_cnt),    e_mism);
    end
  end

  task automatic step(input logic r, input logic d, input logic [2:0] y);
    rst         = r;
    chk.cnt_dir = d;
    chk.y_in    = y;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  c;
    bit  ld, nd, r;
    int  roll;
    logic [2:0] y;

    rst = 1'b0; chk.cnt_dir = 1'b0; chk.y_in = 3'd5;
    @(negedge clk);

    // Reset with y_in = 5
    step(1'b0, 1'b0, 3'd5);
    cmp_en = 1'b1;
    step(1'b0, 1'b0, 3'd5);
    check("rst_step_ok", 32'(chk.step_ok), 0);
    check("rst_err", 32'(chk.err_flag), 0);
    check("rst_dir_state", 32'(chk.dir_state), 0);
    check("rst_mism", 32'(chk.mism_cnt), 0);

    // Up count 0..7,0,1
    step(1'b1, 1'b1, 3'd0);
    check("idle_dir_state", 32'(chk.dir_state), 0);
    check("idle_step_ok", 32'(chk.step_ok), 0);
    for (int k = 1; k < 8; k++) step(1'b1, 1'b1, 3'(k));
    step(1'b1, 1'b1, 3'd0);
    step(1'b1, 1'b1, 3'd1);
    check("up_wrap_up", 32'(chk.wrap_up_cnt), 1);
    check("up_dir_state", 32'(chk.dir_state), 1);
    check("up_step_ok", 32'(chk.step_ok), 1);
    check("up_err", 32'(chk.err_flag), 0);

    // Turn around: 1->2 still up, then 2,1,0,7,6 down
    step(1'b1, 1'b0, 3'd2);
    step(1'b1, 1'b0, 3'd1);
    step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd7);
    step(1'b1, 1'b0, 3'd6);
    check("dn_wrap_dn", 32'(chk.wrap_dn_cnt), 1);
    check("dn_dir_state", 32'(chk.dir_state), 2);
    check("dn_step_ok", 32'(chk.step_ok), 1);
    check("dn_err", 32'(chk.err_flag), 0);

    // Illegal jump 4->6, resync on 7, then 7->0 accepted
    step(1'b0, 1'b1, 3'd0);
    step(1'b1, 1'b1, 3'd3);
    step(1'b1, 1'b1, 3'd4);
    step(1'b1, 1'b1, 3'd6);
    check("jump_err", 32'(chk.err_flag), 1);
    check("jump_mism", 32'(chk.mism_cnt), 1);
    check("jump_dir_state", 32'(chk.dir_state), 3);
    check("jump_step_ok", 32'(chk.step_ok), 0);
    step(1'b1, 1'b1, 3'd7);
    check("resync_dir_state", 32'(chk.dir_state), 1);
    check("resync_step_ok", 32'(chk.step_ok), 0);
    step(1'b1, 1'b1, 3'd0);
    check("after_step_ok", 32'(chk.step_ok), 1);
    check("after_err", 32'(chk.err_flag), 1);
    check("after_wrap_up", 32'(chk.wrap_up_cnt), 1);

    // Hold at 4 for two cycles
    step(1'b0, 1'b1, 3'd0);
    step(1'b1, 1'b1, 3'd3);
    step(1'b1, 1'b1, 3'd4);
    step(1'b1, 1'b1, 3'd4);
    step(1'b1, 1'b1, 3'd4);
`ifdef SEQCHK_HOLD_EN
    check("hold_err", 32'(chk.err_flag), 0);
    check("hold_mism", 32'(chk.mism_cnt), 0);
    check("hold_step_ok", 32'(chk.step_ok), 0);
    check("hold_dir_state", 32'(chk.dir_state), 1);
`else
    check("hold_err", 32'(chk.err_flag), 1);
    check("hold_mism", 32'(chk.mism_cnt), 1);
`endif

    // Direction reversal with no gap: 3->4 up, 4->3 down
    step(1'b0, 1'b1, 3'd0);
    step(1'b1, 1'b1, 3'd3);
    step(1'b1, 1'b0, 3'd4);
    check("rev_up_step_ok", 32'(chk.step_ok), 1);
    check("rev_up_dir_state", 32'(chk.dir_state), 1);
    step(1'b1, 1'b0, 3'd3);
    check("rev_dn_step_ok", 32'(chk.step_ok), 1);
    check("rev_dn_dir_state", 32'(chk.dir_state), 2);
    check("rev_err", 32'(chk.err_flag), 0);

    // 259 up-wraps saturate at 255, then a mid-stream reset clears everything
    step(1'b0, 1'b1, 3'd0);
    step(1'b1, 1'b1, 3'd0);
    for (int i = 1; i <= 8 * (CNT_MAX + 4); i++) step(1'b1, 1'b1, 3'(i % 8));
    check("sat_wrap_up", 32'(chk.wrap_up_cnt), CNT_MAX);
    check("sat_err", 32'(chk.err_flag), 0);
    step(1'b0, 1'b1, 3'd1);
    check("midrst_wrap_up", 32'(chk.wrap_up_cnt), 0);
    check("midrst_dir_state", 32'(chk.dir_state), 0);
    check("midrst_step_ok", 32'(chk.step_ok), 0);
    step(1'b1, 1'b1, 3'd2);
    check("midrst_idle_dir_state", 32'(chk.dir_state), 0);

    // Alternating 0/4 gives one mismatch every two cycles; mism_cnt saturates
    step(1'b0, 1'b1, 3'd0);
    step(1'b1, 1'b1, 3'd0);
    for (int i = 1; i <= 600; i++) step(1'b1, 1'b1, (i % 2 != 0) ? 3'd4 : 3'd0);
    check("sat_mism", 32'(chk.mism_cnt), CNT_MAX);
    check("sat_mism_err", 32'(chk.err_flag), 1);

    // Random: mostly legal steps, some holds, jumps, direction flips and resets
    step(1'b0, 1'b1, 3'd0);
    c  = 0;
    ld = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      r    = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
      roll = int'($urandom_range(99));
      if (roll < 85)      y = ld ? 3'((c + 1) % 8) : 3'((c + 7) % 8);
      else if (roll < 92) y = 3'(c);
      else                y = 3'($urandom_range(7));
      nd = ($urandom_range(4) == 0) ? !ld : ld;
      step(r, nd, y);
      c  = int'(y);
      ld = nd;
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
